// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one memory/IO port between the multicycle CPU
// controller (port 0) and a DMA/display engine (port 1). Each access runs
// IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE. DONE returns a one-cycle
// ready pulse to the owner. A CPU streak limit keeps the DMA from starving.

module mio_bus_arbiter #(
   parameter int WAIT_CYCLES    = 2,  // access latency, 1..15
   parameter int MAX_CPU_GRANTS = 4   // back-to-back CPU wins before DMA is forced, 1..15
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,

   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_ready,

   output logic [31:0] rdata,

   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,

   output logic [1:0]  grant,
   output logic [1:0]  state_out
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_DONE   = 2'b10
   } state_t;

   localparam logic [1:0] LP_GRANT_NONE = 2'b00;
   localparam logic [1:0] LP_GRANT_CPU  = 2'b01;
   localparam logic [1:0] LP_GRANT_DMA  = 2'b10;

   // The counter is loaded so that it reaches zero on the last ACCESS cycle.
   localparam logic [3:0] LP_CNT_LOAD   = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] LP_STREAK_MAX = 4'(MAX_CPU_GRANTS);

   state_t      r_state;
   logic [3:0]  r_wait_cnt;
   logic [3:0]  r_cpu_streak;
   logic [1:0]  r_grant;
   logic        r_cpu_ready;
   logic        r_dma_ready;
   logic        r_mem_en;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;

   logic        w_any_req;
   logic        w_pick_dma;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;

   // Arbitration: pick the winner and mux its request fields.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      w_any_req   = cpu_req | dma_req;
      w_pick_dma  = dma_req & (~cpu_req | (r_cpu_streak == LP_STREAK_MAX));
      w_sel_we    = cpu_we;
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
      if (w_pick_dma) begin
         w_sel_we    = dma_we;
         w_sel_addr  = dma_addr;
         w_sel_wdata = dma_wdata;
      end
   end

   // Access sequencer: a single FSM that owns every registered output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
         r_state      <= S_IDLE;
         r_wait_cnt   <= 4'd0;
         r_cpu_streak <= 4'd0;
         r_grant      <= LP_GRANT_NONE;
         r_cpu_ready  <= 1'b0;
         r_dma_ready  <= 1'b0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 32'd0;
         r_mem_wdata  <= 32'd0;
         r_rdata      <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cpu_ready <= 1'b0;
               r_dma_ready <= 1'b0;
               if (w_any_req) begin
                  r_state     <= S_ACCESS;
                  r_wait_cnt  <= LP_CNT_LOAD;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= w_sel_we;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
                  if (w_pick_dma) begin
                     r_grant      <= LP_GRANT_DMA;
                     r_cpu_streak <= 4'd0;
                  end else begin
                     r_grant <= LP_GRANT_CPU;
                     if (r_cpu_streak != LP_STREAK_MAX) begin
                        r_cpu_streak <= r_cpu_streak + 4'd1;
                     end
                  end
               end else begin
                  r_grant <= LP_GRANT_NONE;
               end
            end

            S_ACCESS: begin
               if (r_wait_cnt == 4'd0) begin
                  // Last access cycle: read data is valid now; writes leave rdata alone.
                  if (!r_mem_we) begin
                     r_rdata <= mem_rdata;
                  end
                  r_mem_en    <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_cpu_ready <= (r_grant == LP_GRANT_CPU);
                  r_dma_ready <= (r_grant == LP_GRANT_DMA);
                  r_state     <= S_DONE;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end

            S_DONE: begin
               r_cpu_ready <= 1'b0;
               r_dma_ready <= 1'b0;
               r_grant     <= LP_GRANT_NONE;
               r_state     <= S_IDLE;
            end

            default: begin
               // Unreachable encoding: recover to the reset condition.
               r_state      <= S_IDLE;
               r_wait_cnt   <= 4'd0;
               r_cpu_streak <= 4'd0;
               r_grant      <= LP_GRANT_NONE;
               r_cpu_ready  <= 1'b0;
               r_dma_ready  <= 1'b0;
               r_mem_en     <= 1'b0;
               r_mem_we     <= 1'b0;
               r_mem_addr   <= 32'd0;
               r_mem_wdata  <= 32'd0;
               r_rdata      <= 32'd0;
            end
         endcase
      end
   end

   assign cpu_ready = r_cpu_ready;
   assign dma_ready = r_dma_ready;
   assign rdata     = r_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign grant     = r_grant;
   assign state_out = r_state;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a transaction-level model. The model tracks only
// the age of the current access and the CPU streak.

module tb_mio_bus_arbiter;

   localparam int WAIT_CYCLES    = 2;
   localparam int MAX_CPU_GRANTS = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
   logic        cpu_ready, dma_ready, mem_en, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [1:0]  grant, state_out;

   mio_bus_arbiter #(
      .WAIT_CYCLES    (WAIT_CYCLES),
      .MAX_CPU_GRANTS (MAX_CPU_GRANTS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_ready (dma_ready),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .grant     (grant),
      .state_out (state_out)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: age 0 = idle, 1..WAIT_CYCLES = access, WAIT_CYCLES+1 = done.
   int          m_age;
   int          m_streak;
   logic [1:0]  m_owner;
   logic        m_we;
   logic [31:0] m_addr, m_wdata, m_rdata;

   logic [1:0]  dut_grants[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_age    = 0;
      m_streak = 0;
      m_owner  = 2'b00;
      m_we     = 1'b0;
      m_addr   = 32'd0;
      m_wdata  = 32'd0;
      m_rdata  = 32'd0;
   endtask

   // Advance the model by one clock, using the inputs currently applied.
   task automatic model_step();
      bit dma_wins;
      if (m_age == 0) begin
         if (cpu_req || dma_req) begin
            dma_wins = dma_req && (!cpu_req || m_streak == MAX_CPU_GRANTS);
            if (dma_wins) begin
               m_owner  = 2'b10;
               m_we     = dma_we;
               m_addr   = dma_addr;
               m_wdata  = dma_wdata;
               m_streak = 0;
            end else begin
               m_owner  = 2'b01;
               m_we     = cpu_we;
               m_addr   = cpu_addr;
               m_wdata  = cpu_wdata;
               m_streak = (m_streak < MAX_CPU_GRANTS) ? m_streak + 1 : MAX_CPU_GRANTS;
            end
            m_age = 1;
         end
      end else if (m_age == WAIT_CYCLES) begin
         if (!m_we) m_rdata = mem_rdata;
         m_age = WAIT_CYCLES + 1;
      end else if (m_age == WAIT_CYCLES + 1) begin
         m_age = 0;
      end else begin
         m_age++;
      end
   endtask

   task automatic check_outputs();
      logic       e_en;
      logic [1:0] e_state, e_grant;
      e_en    = (m_age >= 1) && (m_age <= WAIT_CYCLES);
      e_state = (m_age == 0) ? 2'b00 : (e_en ? 2'b01 : 2'b10);
      e_grant = (m_age == 0) ? 2'b00 : m_owner;
      check("state_out", 32'(state_out), 32'(e_state));
      check("grant",     32'(grant),     32'(e_grant));
      check("mem_en",    32'(mem_en),    32'(e_en));
      check("mem_we",    32'(mem_we),    32'(e_en & m_we));
      if (e_en) begin
         check("mem_addr",  mem_addr,  m_addr);
         check("mem_wdata", mem_wdata, m_wdata);
      end
      check("cpu_ready", 32'(cpu_ready), 32'((m_age == WAIT_CYCLES + 1) && (m_owner == 2'b01)));
      check("dma_ready", 32'(dma_ready), 32'((m_age == WAIT_CYCLES + 1) && (m_owner == 2'b10)));
      check("rdata",     rdata,          m_rdata);
      if (m_age == 1) dut_grants.push_back(grant);
   endtask

   // Called at a falling edge with inputs applied; returns at the next falling edge.
   task automatic step();
      check_outputs();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_state_out", 32'(state_out), 32'd0);
      check("rst_grant",     32'(grant),     32'd0);
      check("rst_mem_en",    32'(mem_en),    32'd0);
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      check("rst_dma_ready", 32'(dma_ready), 32'd0);
      check("rst_mem_addr",  mem_addr,       32'd0);
      check("rst_mem_wdata", mem_wdata,      32'd0);
      check("rst_rdata",     rdata,          32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
   endtask

   initial begin
      logic [1:0] exp_seq [10];
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

      reset = 1'b1;
      idle_inputs();
      mem_rdata = 32'd0;
      model_reset();
      @(negedge clk);
      do_reset();

      // 1: single CPU read
      cpu_req = 1'b1; cpu_addr = 32'h0000_0010; mem_rdata = 32'hDEAD_BEEF;
      step();
      cpu_req = 1'b0;
      for (int i = 0; i < 5; i++) step();

      // 2: DMA write, rdata must keep the previous read value
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0100; dma_wdata = 32'h1234_5678;
      mem_rdata = 32'hCAFE_F00D;
      step();
      dma_req = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("dma_write_keeps_rdata", rdata, 32'hDEAD_BEEF);

      // 3: fairness with both requests held
      do_reset();
      dut_grants.delete();
      cpu_req = 1'b1; dma_req = 1'b1; dma_we = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cpu_addr  = $urandom;
         dma_addr  = $urandom;
         mem_rdata = $urandom;
         step();
      end
      check("fair_count", 32'(dut_grants.size()), 32'd10);
      for (int i = 0; i < 10 && i < dut_grants.size(); i++) begin
         check($sformatf("fair_grant%0d", i), 32'(dut_grants[i]), 32'(exp_seq[i]));
      end

      // 4: reset in the second ACCESS cycle of a CPU write
      idle_inputs();
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0080; cpu_wdata = 32'hA5A5_5A5A;
      step();
      cpu_req = 1'b0;
      step();
      check_outputs();
      do_reset();
      cpu_we = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h0000_0044; mem_rdata = 32'h0BAD_F00D;
      step();
      cpu_req = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("post_reset_read", rdata, 32'h0BAD_F00D);

      // 5 and 6: request dropped after cycle 0, address changed during ACCESS
      cpu_req = 1'b1; cpu_addr = 32'h0000_0020;
      step();
      cpu_req = 1'b0; cpu_addr = 32'h0000_0040;
      for (int i = 0; i < 6; i++) step();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cpu_req   = ($urandom_range(0, 9) < 6);
         dma_req   = ($urandom_range(0, 9) < 4);
         cpu_we    = $urandom_range(0, 1);
         dma_we    = $urandom_range(0, 1);
         cpu_addr  = $urandom;
         dma_addr  = $urandom;
         cpu_wdata = $urandom;
         dma_wdata = $urandom;
         mem_rdata = $urandom;
         if ($urandom_range(0, 199) == 0) do_reset();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
